// File: rtl/instr_mem_loader_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : instr_loader_pkg
// Description : Shared constants and FSM state type for the instruction-memory
//               loader (byte-stream to 19-bit instruction packer).
// Revision    : 1.0 - initial release
// ============================================================================
package instr_loader_pkg;

    localparam int ADDR_W          = 12;
    localparam int INSTR_W         = 19;
    localparam int BYTES_PER_INSTR = 3;
    localparam int HDR_BYTES       = 2;
    localparam int PACK_W          = 8 * BYTES_PER_INSTR;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_HDR_HI = 4'd1,
        ST_HDR_LO = 4'd2,
        ST_B0     = 4'd3,
        ST_B1     = 4'd4,
        ST_B2     = 4'd5,
        ST_WRITE  = 4'd6,
        ST_CHK    = 4'd7,
        ST_DONE   = 4'd8,
        ST_ERR    = 4'd9
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_mem_loader_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : instr_mem_loader_if
// Description : Byte-stream input handshake plus instruction-memory write port
//               of the loader. master = stream source / memory, slave = loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_mem_loader_if;
    import instr_loader_pkg::*;

    logic               in_valid;
    logic [7:0]         in_data;
    logic               in_ready;
    logic               im_we;
    logic [ADDR_W-1:0]  im_addr;
    logic [INSTR_W-1:0] im_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, im_we, im_addr, im_wdata
    );
endinterface
`default_nettype wire

// File: rtl/instr_mem_loader_packer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : instr_byte_packer
// Description : 24-bit big-endian byte shift register. load starts a new word
//               with the given byte, shift appends a byte, clr empties it.
//               Presents the low 19 bits and a flag for nonzero top 5 bits.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_byte_packer
    import instr_loader_pkg::*;
(
    input  wire logic               clk,
    input  wire logic               rst,      // asynchronous, active-low
    input  wire logic               clr,
    input  wire logic               load,
    input  wire logic               shift,
    input  wire logic [7:0]         data_in,
    output logic      [INSTR_W-1:0] word,
    output logic                    hi_nz
);

    logic [PACK_W-1:0] r_shift;

    // Byte assembly register; load has priority over shift so a new word never
    // inherits bytes from the previous instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift <= '0;
        end else if (clr) begin
            r_shift <= '0;
        end else if (load) begin
            r_shift <= {{(PACK_W-8){1'b0}}, data_in};
        end else if (shift) begin
            r_shift <= {r_shift[PACK_W-9:0], data_in};
        end
    end

    // Split the assembled bytes into instruction bits and illegal high bits.
    always_comb begin
        word  = r_shift[INSTR_W-1:0];
        hi_nz = |r_shift[PACK_W-1:INSTR_W];
    end

endmodule
`default_nettype wire

// File: rtl/instr_mem_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : instr_mem_loader
// Description : Fills instruction memory from a byte stream: 2-byte header
//               (instruction count), then 3 bytes per instruction, written to
//               consecutive addresses from 0. Holds the CPU in reset until a
//               load completes cleanly.
//               Optional macro LOADER_CHECKSUM_EN adds a trailing XOR
//               checksum byte verified before declaring the load done.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_loader
    import instr_loader_pkg::*;
(
    input  wire logic           clk,
    input  wire logic           rst,        // asynchronous, active-low
    input  wire logic           start,
    instr_mem_loader_if.slave   bus,
    output logic                cpu_hold,
    output logic                done,
    output logic                err
);

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t c_end_state = ST_CHK;
`else
    localparam loader_state_t c_end_state = ST_DONE;
`endif

    loader_state_t      r_state;
    loader_state_t      w_next;
    logic [ADDR_W-1:0]  r_count;      // instructions still to write
    logic [ADDR_W-1:0]  r_addr;       // address of the next write
    logic [ADDR_W-1:0]  r_im_addr;    // last written address, held between writes
    logic [INSTR_W-1:0] r_im_wdata;   // last written data, held between writes
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]         r_csum;
`endif

    logic               w_ready;
    logic               w_xfer;
    logic               w_start_ok;
    logic [ADDR_W-1:0]  w_n_hdr;
    logic [INSTR_W-1:0] w_word;
    logic               w_hi_nz;

    assign w_xfer     = bus.in_valid & w_ready;
    assign w_start_ok = start & ((r_state == ST_IDLE) | (r_state == ST_DONE) |
                                 (r_state == ST_ERR));
    assign w_n_hdr    = {r_count[ADDR_W-1:8], bus.in_data};

    instr_byte_packer u_packer (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_start_ok),
        .load    ((r_state == ST_B0) & w_xfer),
        .shift   (((r_state == ST_B1) | (r_state == ST_B2)) & w_xfer),
        .data_in (bus.in_data),
        .word    (w_word),
        .hi_nz   (w_hi_nz)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; stream states advance only on an accepted byte.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: if (start) w_next = ST_HDR_HI;
            ST_HDR_HI: if (w_xfer) w_next = ST_HDR_LO;
            ST_HDR_LO: if (w_xfer) w_next = (w_n_hdr == '0) ? c_end_state : ST_B0;
            ST_B0:     if (w_xfer) w_next = (|bus.in_data[7:3]) ? ST_ERR : ST_B1;
            ST_B1:     if (w_xfer) w_next = ST_B2;
            ST_B2:     if (w_xfer) w_next = ST_WRITE;
            // hi_nz cannot be set after a legal byte0; it is a guard against
            // ever writing a word with illegal high bits.
            ST_WRITE:  w_next = w_hi_nz ? ST_ERR :
                                (r_count == ADDR_W'(1)) ? c_end_state : ST_B0;
`ifdef LOADER_CHECKSUM_EN
            ST_CHK:    if (w_xfer) w_next = ((r_csum ^ bus.in_data) == 8'h00) ?
                                            ST_DONE : ST_ERR;
`endif
            default:   w_next = ST_IDLE;
        endcase
    end

    // Moore outputs; write address/data hold their last value outside WRITE.
    always_comb begin
        w_ready = (r_state == ST_HDR_HI) | (r_state == ST_HDR_LO) |
                  (r_state == ST_B0) | (r_state == ST_B1) | (r_state == ST_B2);
`ifdef LOADER_CHECKSUM_EN
        w_ready = w_ready | (r_state == ST_CHK);
`endif
        bus.in_ready = w_ready;
        bus.im_we    = (r_state == ST_WRITE) & ~w_hi_nz;
        bus.im_addr  = (r_state == ST_WRITE) ? r_addr : r_im_addr;
        bus.im_wdata = (r_state == ST_WRITE) ? w_word : r_im_wdata;
        cpu_hold     = (r_state != ST_DONE);
        done         = (r_state == ST_DONE);
        err          = (r_state == ST_ERR);
    end

    // Count, address, held write outputs and running checksum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count    <= '0;
            r_addr     <= '0;
            r_im_addr  <= '0;
            r_im_wdata <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_csum     <= '0;
`endif
        end else begin
            if (w_start_ok) begin
                r_addr <= '0;
            end
            if ((r_state == ST_HDR_HI) && w_xfer) begin
                r_count <= {bus.in_data[ADDR_W-9:0], 8'h00};
            end
            if ((r_state == ST_HDR_LO) && w_xfer) begin
                r_count <= w_n_hdr;
            end
            if (r_state == ST_WRITE) begin
                r_addr     <= r_addr + ADDR_W'(1);
                r_count    <= r_count - ADDR_W'(1);
                r_im_addr  <= r_addr;
                r_im_wdata <= w_word;
            end
`ifdef LOADER_CHECKSUM_EN
            if (w_start_ok) begin
                r_csum <= '0;
            end else if (w_xfer && (r_state != ST_CHK)) begin
                r_csum <= r_csum ^ bus.in_data;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_instr_mem_loader
// Description : Self-checking bench for instr_mem_loader. Stimulus pushes the
//               expected memory writes into a queue; a monitor pops and
//               compares on every im_we pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_mem_loader;
    import instr_loader_pkg::*;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [INSTR_W-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic cpu_hold, done, err;

    instr_mem_loader_if bus();

    instr_mem_loader dut (
        .clk      (clk),
        .rst      (rst_n),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    wr_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n && bus.im_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                         bus.im_addr, bus.im_wdata);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", 32'(bus.im_addr), 32'(e.addr));
                check("write_data", 32'(bus.im_wdata), 32'(e.data));
            end
        end
    end

    // Reference stream: header (random ignored nibble), 3 bytes per
    // instruction, and optionally an XOR checksum (corrupted when bad_sum).
    task automatic build(input logic [INSTR_W-1:0] ins[$], input bit bad_sum,
                         output logic [7:0] s[$]);
        int n;
        logic [7:0] x;
        n = ins.size();
        s = {};
        s.push_back({4'($urandom), 4'(n >> 8)});
        s.push_back(8'(n));
        foreach (ins[i]) begin
            s.push_back({5'b0, ins[i][18:16]});
            s.push_back(ins[i][15:8]);
            s.push_back(ins[i][7:0]);
        end
`ifdef LOADER_CHECKSUM_EN
        x = 8'h00;
        foreach (s[i]) x = x ^ s[i];
        s.push_back(bad_sum ? (x ^ 8'h01) : x);
`else
        x = 8'(bad_sum);
`endif
    endtask

    task automatic expect_writes(input logic [INSTR_W-1:0] ins[$]);
        foreach (ins[i]) exp_q.push_back('{addr: ADDR_W'(i), data: ins[i]});
    endtask

    task automatic rand_instrs(input int n, output logic [INSTR_W-1:0] ins[$]);
        ins = {};
        for (int i = 0; i < n; i++) ins.push_back(INSTR_W'($urandom));
    endtask

    // Start pulse; optionally offers a junk byte in the same cycle.
    task automatic do_start(input bit junk);
        start = 1'b1;
        bus.in_valid = junk;
        bus.in_data = 8'hAA;
        @(posedge clk); #1;
        start = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    // Drive bytes with valid asserted pct% of cycles; bounded per byte.
    task automatic send(input logic [7:0] s[$], input int pct);
        foreach (s[i]) begin
            int waited;
            bit acc;
            waited = 0;
            acc = 1'b0;
            while (!acc) begin
                bus.in_valid = ($urandom_range(99) < pct);
                bus.in_data  = bus.in_valid ? s[i] : 8'($urandom);
                acc = bus.in_valid && bus.in_ready;
                @(posedge clk); #1;
                waited++;
                if (!acc && waited > 200) begin
                    check("byte_accept_timeout", 32'(waited), 32'(0));
                    bus.in_valid = 1'b0;
                    return;
                end
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_end();
        int k;
        k = 0;
        while (!(done || err) && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("end_timeout", 32'(done || err), 32'(1));
    endtask

    task automatic run_load(input logic [INSTR_W-1:0] ins[$], input int pct, input bit bad_sum);
        logic [7:0] s[$];
        build(ins, bad_sum, s);
        expect_writes(ins);
        do_start(1'b1);
        send(s, pct);
        wait_end();
        check("load_done", 32'(done), 32'(!bad_sum));
        check("load_err", 32'(err), 32'(bad_sum));
        check("load_cpu_hold", 32'(cpu_hold), 32'(bad_sum));
        check("writes_outstanding", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [INSTR_W-1:0] ins[$];
        logic [7:0] s[$];
        int k;

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        // Reset values
        check("rst_in_ready", 32'(bus.in_ready), 32'(0));
        check("rst_im_we", 32'(bus.im_we), 32'(0));
        check("rst_im_addr", 32'(bus.im_addr), 32'(0));
        check("rst_im_wdata", 32'(bus.im_wdata), 32'(0));
        check("rst_cpu_hold", 32'(cpu_hold), 32'(1));
        check("rst_done", 32'(done), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed N=2 load
        ins = {19'h7FFFF, 19'h12345};
        run_load(ins, 100, 1'b0);

        // Empty load: hold released right after the last header/checksum byte
        do_start(1'b0);
        check("hold_after_start", 32'(cpu_hold), 32'(1));
        ins = {};
        build(ins, 1'b0, s);
        send(s, 100);
        check("zero_hold_timing", 32'(cpu_hold), 32'(0));
        check("zero_done", 32'(done), 32'(1));

        // Illegal byte0 -> error, then recovery
        do_start(1'b0);
        s = {8'h00, 8'h01, 8'h08};
        send(s, 100);
        check("bad_b0_err", 32'(err), 32'(1));
        check("bad_b0_hold", 32'(cpu_hold), 32'(1));
        check("bad_b0_ready", 32'(bus.in_ready), 32'(0));
        bus.in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("bad_b0_err_stays", 32'(err), 32'(1));
        check("bad_b0_done", 32'(done), 32'(0));
        rand_instrs(3, ins);
        run_load(ins, 100, 1'b0);

        // Throttled N=5 load
        rand_instrs(5, ins);
        run_load(ins, 50, 1'b0);

        // Reset after the second write of an N=4 load
        rand_instrs(4, ins);
        build(ins, 1'b0, s);
        expect_writes(ins);
        do_start(1'b0);
        s = s[0:7];
        send(s, 100);
        k = 0;
        while (exp_q.size() > 2 && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        check("pre_reset_writes", 32'(exp_q.size()), 32'(2));
        #2 rst_n = 1'b0;
        #1;
        check("arst_in_ready", 32'(bus.in_ready), 32'(0));
        check("arst_im_we", 32'(bus.im_we), 32'(0));
        check("arst_im_addr", 32'(bus.im_addr), 32'(0));
        check("arst_im_wdata", 32'(bus.im_wdata), 32'(0));
        check("arst_cpu_hold", 32'(cpu_hold), 32'(1));
        check("arst_done", 32'(done), 32'(0));
        check("arst_err", 32'(err), 32'(0));
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        rand_instrs(4, ins);
        run_load(ins, 100, 1'b0);

        // Random loads with varying throttle
        for (int t = 0; t < 3; t++) begin
            rand_instrs(int'($urandom_range(6, 1)), ins);
            run_load(ins, int'($urandom_range(100, 40)), 1'b0);
        end

`ifdef LOADER_CHECKSUM_EN
        ins = {19'h00005};
        run_load(ins, 100, 1'b0);
        run_load(ins, 100, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
